// File: rtl/cgra_exec_pkg.sv
// Shared types and helpers for the CGRA execution controller.
package cgra_exec_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    PROCESS   = 2'd2,
    DONE      = 2'd3
  } state_t;

  // Widest counter the saturating helper supports.
  localparam int unsigned SAT_W = 64;

  // Increment that sticks at max instead of wrapping.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                               input logic [SAT_W-1:0] max);
    return (value >= max) ? value : value + SAT_W'(1);
  endfunction

endpackage

// File: rtl/cgra_exec_en_pipe.sv
// Fixed-depth delay line carrying the go decision to the array enable.
module cgra_exec_en_pipe #(
  parameter int unsigned DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] stages;

  if (DEPTH == 1) begin : g_single
    // Single stage: register din directly.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   stages <= '0;
      else if (clr) stages <= '0;
      else          stages <= din;
    end
  end else begin : g_multi
    // Shift din in at bit 0; the oldest sample leaves at the top.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   stages <= '0;
      else if (clr) stages <= '0;
      else          stages <= {stages[DEPTH-2:0], din};
    end
  end

  // Output is the last stage.
  always_comb dout = stages[DEPTH-1];

endmodule

// File: rtl/cgra_exec_ctrl.sv
// Execution controller: sequences fetch/fill/process/done and drives the PE enable.
module cgra_exec_ctrl
  import cgra_exec_pkg::*;
#(
  parameter int unsigned NUM_IN     = 8,
  parameter int unsigned NUM_OUT    = 8,
  parameter int unsigned EN_LATENCY = 3,
  parameter int unsigned CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [NUM_IN-1:0]  read_fifo_mask,
  input  logic [NUM_OUT-1:0] write_fifo_mask,
  input  logic [NUM_IN-1:0]  available_read,
  input  logic [NUM_IN-1:0]  available_pop,
  input  logic [NUM_IN-1:0]  read_fifo_done,
  input  logic [NUM_OUT-1:0] available_write,
  input  logic [NUM_OUT-1:0] available_push,
  input  logic [NUM_OUT-1:0] write_fifo_done,
  output logic               en,
  output logic [NUM_IN-1:0]  en_fetch_data,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   exec_cycles,
  output logic [CNT_W-1:0]   stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state, state_next;
  logic [NUM_IN-1:0]  rmask;
  logic [NUM_OUT-1:0] wmask;
  logic               ready_q;
  logic               all_wr_done;
  logic               go;
  logic               start_ok;
  logic               pipe_clr;

  // Queue status reduced against the latched masks; unmasked queues never gate.
  always_comb begin
    all_wr_done = &(write_fifo_done | ~wmask);
    go          = (state == PROCESS) && !all_wr_done
                  && (&(available_read | read_fifo_done | ~rmask))
                  && (&(available_write | ~wmask));
  end

  // Next-state decode; abort overrides every transition including start.
  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    case (state)
      IDLE:      if (start) begin state_next = WAIT_DATA; start_ok = 1'b1; end
      WAIT_DATA: if (ready_q) state_next = PROCESS;
      PROCESS:   if (all_wr_done) state_next = DONE;
      DONE:      if (start) begin state_next = WAIT_DATA; start_ok = 1'b1; end
      default:   state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
      start_ok   = 1'b0;
    end
    pipe_clr = abort || ((state == PROCESS) && (state_next != PROCESS));
    busy     = (state == WAIT_DATA) || (state == PROCESS);
    done     = (state == DONE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Run context: masks and fetch enables latched on an accepted start.
  // ready_q is forced low on start so WAIT_DATA never acts on a value
  // computed against the previous run's masks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rmask         <= '0;
      wmask         <= '0;
      en_fetch_data <= '0;
      ready_q       <= 1'b0;
    end else begin
      if (abort) begin
        en_fetch_data <= '0;
      end else if (start_ok) begin
        rmask         <= read_fifo_mask;
        wmask         <= write_fifo_mask;
        en_fetch_data <= read_fifo_mask;
      end
      ready_q <= start_ok ? 1'b0
                          : ((&(available_pop | ~rmask)) && (&(available_push | ~wmask)));
    end
  end

  // Performance counters: cleared on start, saturating, frozen on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_cycles  <= '0;
      stall_cycles <= '0;
    end else if (start_ok) begin
      exec_cycles  <= '0;
      stall_cycles <= '0;
    end else if ((state == PROCESS) && !abort) begin
      exec_cycles <= CNT_W'(sat_inc(SAT_W'(exec_cycles), SAT_W'(CNT_MAX)));
      if (!go) stall_cycles <= CNT_W'(sat_inc(SAT_W'(stall_cycles), SAT_W'(CNT_MAX)));
    end
  end

  cgra_exec_en_pipe #(.DEPTH(EN_LATENCY)) u_en_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (pipe_clr),
    .din   (go),
    .dout  (en)
  );

endmodule

// File: tb/tb_cgra_exec_ctrl.sv
// Scoreboard bench for cgra_exec_ctrl: stimulus queues timed expectations, monitor checks them.
module tb_cgra_exec_ctrl;

  localparam int F_EN = 0, F_BUSY = 1, F_DONE = 2, F_EXEC = 3, F_STALL = 4, F_EFD = 5, F_EXEC4 = 6;

  typedef struct {
    int unsigned at;
    int          f;
    logic [31:0] v;
    string       n;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, start, abort;
  logic [7:0] read_fifo_mask, write_fifo_mask, available_read, available_pop, read_fifo_done;
  logic [7:0] available_write, available_push, write_fifo_done;
  logic en, busy, done;
  logic [7:0] en_fetch_data;
  logic [31:0] exec_cycles, stall_cycles;
  logic en4, busy4, done4;
  logic [7:0] en_fetch_data4;
  logic [3:0] exec_cycles4, stall_cycles4;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] act;

  always #5 clk = ~clk;

  cgra_exec_ctrl #(.NUM_IN(8), .NUM_OUT(8), .EN_LATENCY(3), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .read_fifo_mask(read_fifo_mask), .write_fifo_mask(write_fifo_mask),
    .available_read(available_read), .available_pop(available_pop),
    .read_fifo_done(read_fifo_done), .available_write(available_write),
    .available_push(available_push), .write_fifo_done(write_fifo_done),
    .en(en), .en_fetch_data(en_fetch_data), .busy(busy), .done(done),
    .exec_cycles(exec_cycles), .stall_cycles(stall_cycles)
  );

  cgra_exec_ctrl #(.NUM_IN(8), .NUM_OUT(8), .EN_LATENCY(3), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .read_fifo_mask(read_fifo_mask), .write_fifo_mask(write_fifo_mask),
    .available_read(available_read), .available_pop(available_pop),
    .read_fifo_done(read_fifo_done), .available_write(available_write),
    .available_push(available_push), .write_fifo_done(write_fifo_done),
    .en(en4), .en_fetch_data(en_fetch_data4), .busy(busy4), .done(done4),
    .exec_cycles(exec_cycles4), .stall_cycles(stall_cycles4)
  );

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] field(input int f);
    case (f)
      F_EN:    return {31'd0, en};
      F_BUSY:  return {31'd0, busy};
      F_DONE:  return {31'd0, done};
      F_EXEC:  return exec_cycles;
      F_STALL: return stall_cycles;
      F_EFD:   return {24'd0, en_fetch_data};
      default: return {28'd0, exec_cycles4};
    endcase
  endfunction

  // Monitor: compare every expectation whose cycle has come due.
  always @(negedge clk) begin
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        act = field(sb[i].f);
        n_tests++;
        if (sb[i].at != cyc) begin
          n_fail++;
          $display("FAIL %s: sample for cycle %0d missed (now %0d)", sb[i].n, sb[i].at, cyc);
        end else if (act !== sb[i].v) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got %0h expected %0h", sb[i].n, cyc, act, sb[i].v);
        end
        sb.delete(i);
      end
    end
  end

  task automatic chk(input int unsigned d, input int f, input logic [31:0] v, input string n);
    exp_t e;
    e.at = cyc + d;
    e.f  = f;
    e.v  = v;
    e.n  = n;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    read_fifo_mask = '0; write_fifo_mask = '0; read_fifo_done = '0; write_fifo_done = '0;
    available_read = 8'hFF; available_pop = 8'hFF; available_write = 8'hFF; available_push = 8'hFF;

    // Reset state
    repeat (2) tick();
    chk(0, F_EN, 0, "rst_en"); chk(0, F_BUSY, 0, "rst_busy"); chk(0, F_DONE, 0, "rst_done");
    chk(0, F_EXEC, 0, "rst_exec"); chk(0, F_STALL, 0, "rst_stall"); chk(0, F_EFD, 0, "rst_efd");
    tick();
    rst_n = 1'b1;
    tick();

    // 1 Nominal run: WAIT_DATA at +1, PROCESS at +3, en at +6
    read_fifo_mask = 8'h0F; write_fifo_mask = 8'h03; start = 1'b1;
    chk(1, F_BUSY, 1, "t1_busy"); chk(1, F_EFD, 32'h0F, "t1_efd"); chk(1, F_DONE, 0, "t1_done");
    chk(3, F_EXEC, 0, "t1_exec_entry"); chk(4, F_EXEC, 1, "t1_exec_first");
    chk(5, F_EN, 0, "t1_en_before"); chk(6, F_EN, 1, "t1_en_rise");
    chk(6, F_EXEC, 3, "t1_exec"); chk(6, F_STALL, 0, "t1_stall0");
    tick(); start = 1'b0;
    repeat (6) tick();

    // 2 Stall on masked write queue for 5 cycles
    available_write = 8'hFD;
    chk(2, F_EN, 1, "t2_en_pre"); chk(3, F_EN, 0, "t2_en_gap_lo"); chk(7, F_EN, 0, "t2_en_gap_hi");
    chk(8, F_EN, 1, "t2_en_back"); chk(5, F_STALL, 5, "t2_stall"); chk(8, F_STALL, 5, "t2_stall_hold");
    chk(8, F_EXEC, 12, "t2_exec");
    repeat (5) tick();
    available_write = 8'hFF;
    repeat (3) tick();
    // Unmasked queue dropping has no effect
    available_write = 8'hDF;
    for (int d = 1; d <= 3; d++) chk(d, F_EN, 1, "t2_unmasked_en");
    chk(3, F_STALL, 5, "t2_unmasked_stall");
    repeat (3) tick();
    available_write = 8'hFF;

    // Completion -> DONE, pipe cleared
    write_fifo_done = 8'h03;
    chk(0, F_EN, 1, "t1_en_last"); chk(1, F_DONE, 1, "t1_done_hi"); chk(1, F_BUSY, 0, "t1_busy_lo");
    chk(1, F_EN, 0, "t1_en_fall"); chk(1, F_EXEC, 16, "t1_exec_final"); chk(1, F_STALL, 6, "t1_stall_final");
    repeat (3) tick();
    chk(0, F_DONE, 1, "t1_done_held"); chk(0, F_EXEC, 16, "t1_exec_held"); chk(0, F_EFD, 32'h0F, "t1_efd_held");

    // 4 Restart from DONE with new mask
    write_fifo_done = 8'h00; read_fifo_mask = 8'h01; start = 1'b1;
    chk(1, F_DONE, 0, "t4_done"); chk(1, F_BUSY, 1, "t4_busy"); chk(1, F_EXEC, 0, "t4_exec");
    chk(1, F_STALL, 0, "t4_stall"); chk(1, F_EFD, 32'h01, "t4_efd"); chk(6, F_EN, 1, "t4_en");
    tick(); start = 1'b0;
    repeat (2) tick();
    // start while in PROCESS is ignored
    start = 1'b1; read_fifo_mask = 8'hFF;
    chk(1, F_EFD, 32'h01, "t4_ign_efd"); chk(1, F_BUSY, 1, "t4_ign_busy"); chk(2, F_EXEC, 2, "t4_ign_exec");
    tick(); start = 1'b0; read_fifo_mask = 8'h01;
    repeat (3) tick();

    // 3 Abort in PROCESS with en high
    chk(0, F_EN, 1, "t3_en_pre"); chk(0, F_EXEC, 4, "t3_exec_pre");
    abort = 1'b1;
    chk(1, F_BUSY, 0, "t3_busy"); chk(1, F_EN, 0, "t3_en"); chk(1, F_EFD, 0, "t3_efd");
    chk(1, F_EXEC, 4, "t3_exec_frozen"); chk(1, F_STALL, 0, "t3_stall_frozen");
    chk(3, F_EXEC, 4, "t3_exec_hold"); chk(3, F_DONE, 0, "t3_done");
    tick(); abort = 1'b0;
    repeat (2) tick();

    // 5 Degenerate: empty write mask
    read_fifo_mask = 8'h0F; write_fifo_mask = 8'h00; start = 1'b1;
    chk(1, F_BUSY, 1, "t5_busy"); chk(3, F_BUSY, 1, "t5_busy_proc"); chk(4, F_DONE, 1, "t5_done");
    chk(4, F_EXEC, 1, "t5_exec"); chk(4, F_STALL, 1, "t5_stall");
    for (int d = 1; d <= 7; d++) chk(d, F_EN, 0, "t5_en_never");
    tick(); start = 1'b0;
    repeat (4) tick();
    abort = 1'b1;
    chk(1, F_DONE, 0, "t5_abort_done"); chk(1, F_EXEC, 1, "t5_abort_exec");
    tick(); abort = 1'b0;
    // start + abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    chk(1, F_BUSY, 0, "t5_sa_busy"); chk(1, F_DONE, 0, "t5_sa_done"); chk(1, F_EXEC, 1, "t5_sa_exec");
    chk(1, F_EFD, 0, "t5_sa_efd"); chk(2, F_BUSY, 0, "t5_sa_busy2");
    tick(); start = 1'b0; abort = 1'b0;
    tick();

    // 6a Async reset mid-PROCESS
    read_fifo_mask = 8'h0F; write_fifo_mask = 8'h03; start = 1'b1;
    chk(6, F_EN, 1, "t6_en_pre");
    tick(); start = 1'b0;
    repeat (6) tick();
    #1 rst_n = 1'b0;
    chk(0, F_EN, 0, "t6_en"); chk(0, F_BUSY, 0, "t6_busy"); chk(0, F_EXEC, 0, "t6_exec");
    chk(0, F_EFD, 0, "t6_efd"); chk(0, F_STALL, 0, "t6_stall"); chk(0, F_EXEC4, 0, "t6_exec4");
    #5 rst_n = 1'b1;
    tick();

    // 6b Saturation with CNT_W=4; empty read mask so read inputs are irrelevant
    read_fifo_mask = 8'h00; available_read = 8'h00; available_pop = 8'h00; start = 1'b1;
    chk(3, F_BUSY, 1, "t6_sat_busy"); chk(6, F_EN, 1, "t6_rmask0_en");
    chk(17, F_EXEC4, 14, "t6_exec4_14"); chk(18, F_EXEC4, 15, "t6_exec4_15");
    chk(23, F_EXEC4, 15, "t6_exec4_sat"); chk(23, F_EXEC, 20, "t6_exec_20");
    tick(); start = 1'b0;
    repeat (22) tick();
    write_fifo_done = 8'h03;
    chk(1, F_DONE, 1, "t6_done"); chk(1, F_EXEC, 21, "t6_exec_21"); chk(1, F_EXEC4, 15, "t6_exec4_final");
    tick();

    // Drain outstanding expectations with a bounded wait
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations still pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
